// File: rtl/ro_puf_pkg.sv
// Shared types for the ring-oscillator PUF scan path: scan states, default sizes
// and the packed response record handed to host-side consumers.
package ro_puf_pkg;

    localparam int DEF_NUM_RO = 9;
    localparam int DEF_CNT_W  = 32;
    localparam int MAX_NUM_RO = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_HOLD,
        ST_CAPTURE,
        ST_DONE
    } ro_scan_state_e;

    // Sized for the largest supported bank; narrower banks zero-extend.
    typedef struct packed {
        logic [MAX_NUM_RO-2:0] data;
        logic [MAX_NUM_RO-1:0] err;
    } ro_rsp_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ro_scan_scheduler_if.sv
// Host-side challenge/response handshake of the RO scan scheduler.
interface ro_scan_scheduler_if
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO = DEF_NUM_RO
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_challenge;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [NUM_RO-2:0] rsp_data;
    logic [NUM_RO-1:0] rsp_err;

    modport master (
        output req_valid, req_challenge, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_challenge, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ro_pair_compare.sv
// Adjacent-pair comparison of captured counts; dead-oscillator flags are only
// produced when built with RO_SCAN_DEAD_CHECK_EN.
module ro_pair_compare
#(
    parameter int NUM_RO    = 9,
    parameter int CNT_W     = 32,
    parameter int MIN_COUNT = 16
) (
    input  logic [NUM_RO-1:0][CNT_W-1:0] counts,
    output logic [NUM_RO-2:0]            rsp_data,
    output logic [NUM_RO-1:0]            rsp_err
);
`ifdef RO_SCAN_DEAD_CHECK_EN
    localparam bit DEAD_CHECK = 1'b1;
`else
    localparam bit DEAD_CHECK = 1'b0;
`endif

    always_comb begin
        rsp_data = '0;
        rsp_err  = '0;
        for (int i = 0; i < NUM_RO - 1; i++) begin
            rsp_data[i] = counts[i] > counts[i+1];
        end
        // Folds away entirely when the dead check is not built.
        for (int i = 0; i < NUM_RO; i++) begin
            rsp_err[i] = DEAD_CHECK && (counts[i] < CNT_W'(MIN_COUNT));
        end
    end
endmodule

// File: rtl/ro_scan_scheduler.sv
// Cycle-exact sequencer for the RO bank and shared edge counter.
// Optional dead-oscillator flagging is enabled with RO_SCAN_DEAD_CHECK_EN.
module ro_scan_scheduler
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO    = DEF_NUM_RO,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int SETTLE    = 16,
    parameter int WINDOW    = 65536,
    parameter int HOLD      = 4,
    parameter int MIN_COUNT = 16
) (
    input  logic                 count_clk,
    input  logic                 reset,
    ro_scan_scheduler_if.slave   host,
    output logic [5:0]           ro_challenge,
    output logic [NUM_RO-1:0]    ro_en,
    output logic                 cnt_clear,
    output logic                 cnt_gate,
    input  logic [CNT_W-1:0]     cnt_value,
    output logic                 busy
);
    localparam int TW = $clog2(max3(SETTLE, WINDOW, HOLD) + 1);
    localparam logic [3:0] LAST = 4'(NUM_RO - 1);

    ro_scan_state_e state, state_next;
    logic [3:0]     idx, idx_next;
    logic [TW-1:0]  tcnt, tcnt_next;
    logic           req_ready, rsp_valid;

    logic [NUM_RO-1:0][CNT_W-1:0] counts, cmp_counts;
    logic [NUM_RO-2:0]            cmp_data, rsp_data_q;
    logic [NUM_RO-1:0]            cmp_err, rsp_err_q;

    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            tcnt  <= tcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        tcnt_next  = tcnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ro_en      = '0;
        cnt_clear  = 1'b1;
        cnt_gate   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (host.req_valid) begin
                    state_next = ST_SETTLE;
                    idx_next   = '0;
                    tcnt_next  = '0;
                end
            end
            ST_SETTLE: begin
                for (int i = 0; i < NUM_RO; i++) ro_en[i] = (idx == 4'(i));
                tcnt_next = tcnt + TW'(1);
                if (tcnt == TW'(SETTLE - 1)) begin
                    tcnt_next  = '0;
                    state_next = ST_GATE;
                end
            end
            ST_GATE: begin
                for (int i = 0; i < NUM_RO; i++) ro_en[i] = (idx == 4'(i));
                cnt_clear = 1'b0;
                cnt_gate  = 1'b1;
                tcnt_next = tcnt + TW'(1);
                if (tcnt == TW'(WINDOW - 1)) begin
                    tcnt_next  = '0;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                for (int i = 0; i < NUM_RO; i++) ro_en[i] = (idx == 4'(i));
                cnt_clear = 1'b0;
                tcnt_next = tcnt + TW'(1);
                if (tcnt == TW'(HOLD - 1)) begin
                    tcnt_next  = '0;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cnt_clear = 1'b0;
                if (idx == LAST) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx + 4'd1;
                    tcnt_next  = '0;
                    state_next = ST_SETTLE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (host.rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The comparator sees the count being captured this cycle so the response
    // can be registered on the same edge that enters DONE.
    always_comb begin
        cmp_counts = counts;
        for (int i = 0; i < NUM_RO; i++) begin
            if (state == ST_CAPTURE && idx == 4'(i)) cmp_counts[i] = cnt_value;
        end
    end

    ro_pair_compare #(
        .NUM_RO    (NUM_RO),
        .CNT_W     (CNT_W),
        .MIN_COUNT (MIN_COUNT)
    ) u_compare (
        .counts   (cmp_counts),
        .rsp_data (cmp_data),
        .rsp_err  (cmp_err)
    );

    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            ro_challenge <= '0;
            counts       <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= '0;
        end else begin
            if (state == ST_IDLE && host.req_valid) ro_challenge <= host.req_challenge[5:0];
            if (state == ST_CAPTURE) begin
                for (int i = 0; i < NUM_RO; i++) begin
                    if (idx == 4'(i)) counts[i] <= cnt_value;
                end
                if (idx == LAST) begin
                    rsp_data_q <= cmp_data;
                    rsp_err_q  <= cmp_err;
                end
            end
        end
    end

    assign host.req_ready = req_ready;
    assign host.rsp_valid = rsp_valid;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_ro_scan_scheduler.sv
// Self-checking bench for ro_scan_scheduler with a behavioural counter and a
// slot/phase arithmetic model of the scan schedule.
module tb_ro_scan_scheduler;
    localparam int NUM_RO    = 3;
    localparam int CNT_W     = 32;
    localparam int SETTLE    = 2;
    localparam int WINDOW    = 8;
    localparam int HOLD      = 2;
    localparam int MIN_COUNT = 16;
    localparam int P         = SETTLE + WINDOW + HOLD + 1;
    localparam int SCAN      = NUM_RO * P;

    logic              count_clk = 1'b0;
    logic              reset     = 1'b1;
    logic [5:0]        ro_challenge;
    logic [NUM_RO-1:0] ro_en;
    logic              cnt_clear, cnt_gate, busy;
    logic [CNT_W-1:0]  cnt_value = '0;
    logic [CNT_W-1:0]  cfg [NUM_RO];

    int vectors     = 0;
    int miscompares = 0;

    ro_scan_scheduler_if #(.NUM_RO(NUM_RO)) host ();

    ro_scan_scheduler #(
        .NUM_RO    (NUM_RO),
        .CNT_W     (CNT_W),
        .SETTLE    (SETTLE),
        .WINDOW    (WINDOW),
        .HOLD      (HOLD),
        .MIN_COUNT (MIN_COUNT)
    ) dut (
        .count_clk    (count_clk),
        .reset        (reset),
        .host         (host.slave),
        .ro_challenge (ro_challenge),
        .ro_en        (ro_en),
        .cnt_clear    (cnt_clear),
        .cnt_gate     (cnt_gate),
        .cnt_value    (cnt_value),
        .busy         (busy)
    );

    always #5 count_clk = ~count_clk;

    function automatic int oh_index(input logic [NUM_RO-1:0] v);
        for (int i = 0; i < NUM_RO; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Counter model: counts while gated; once the gate has closed it settles to
    // the configured count of whichever oscillator is enabled.
    always @(posedge count_clk) begin
        if (cnt_clear)      cnt_value <= '0;
        else if (cnt_gate)  cnt_value <= cnt_value + 1;
        else if (ro_en != '0) cnt_value <= cfg[oh_index(ro_en)];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_ro_en", 32'(ro_en), 32'd0);
        check_output("rst_cnt_clear", 32'(cnt_clear), 32'd1);
        check_output("rst_cnt_gate", 32'(cnt_gate), 32'd0);
        check_output("rst_req_ready", 32'(host.req_ready), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
        check_output("rst_rsp_data", 32'(host.rsp_data), 32'd0);
        check_output("rst_rsp_err", 32'(host.rsp_err), 32'd0);
        check_output("rst_ro_challenge", 32'(ro_challenge), 32'd0);
    endtask

    // One full scan; abort_at >= 0 asserts reset at that scan cycle instead.
    task automatic apply_stimulus(input logic [7:0] ch, input logic [31:0] c0,
                                  input logic [31:0] c1, input logic [31:0] c2,
                                  input int stall, input bit pulse, input int abort_at);
        logic [NUM_RO-1:0] exp_en, exp_err;
        logic [NUM_RO-2:0] exp_data;
        int slot, phase;
        cfg[0] = c0; cfg[1] = c1; cfg[2] = c2;
        exp_data = {c1 > c2, c0 > c1};
`ifdef RO_SCAN_DEAD_CHECK_EN
        exp_err = {c2 < MIN_COUNT, c1 < MIN_COUNT, c0 < MIN_COUNT};
`else
        exp_err = '0;
`endif
        @(negedge count_clk);
        check_output("idle_req_ready", 32'(host.req_ready), 32'd1);
        host.req_valid     = 1'b1;
        host.req_challenge = ch;
        @(posedge count_clk);
        #1;
        host.req_valid     = 1'b0;
        host.req_challenge = ~ch;
        for (int t = 0; t < SCAN; t++) begin
            @(negedge count_clk);
            slot   = t / P;
            phase  = t % P;
            exp_en = (phase < P - 1) ? NUM_RO'(1) << slot : '0;
            check_output("scan_ro_en", 32'(ro_en), 32'(exp_en));
            check_output("scan_cnt_gate", 32'(cnt_gate), 32'(phase >= SETTLE && phase < SETTLE + WINDOW));
            check_output("scan_cnt_clear", 32'(cnt_clear), 32'(phase < SETTLE));
            check_output("scan_ro_challenge", 32'(ro_challenge), 32'(ch[5:0]));
            check_output("scan_busy", 32'(busy), 32'd1);
            check_output("scan_req_ready", 32'(host.req_ready), 32'd0);
            check_output("scan_rsp_valid", 32'(host.rsp_valid), 32'd0);
            if (t == abort_at) begin
                #1 reset = 1'b1;
                #1 check_reset_values();
                @(negedge count_clk);
                reset = 1'b0;
                host.req_valid = 1'b0;
                return;
            end
            if (pulse && t == 10) host.req_valid = 1'b1;
            if (pulse && t == 14) host.req_valid = 1'b0;
        end
        @(negedge count_clk);
        check_output("done_rsp_valid", 32'(host.rsp_valid), 32'd1);
        check_output("done_rsp_data", 32'(host.rsp_data), 32'(exp_data));
        check_output("done_rsp_err", 32'(host.rsp_err), 32'(exp_err));
        check_output("done_ro_en", 32'(ro_en), 32'd0);
        check_output("done_busy", 32'(busy), 32'd1);
        for (int k = 0; k < stall; k++) begin
            @(negedge count_clk);
            check_output("stall_rsp_valid", 32'(host.rsp_valid), 32'd1);
            check_output("stall_rsp_data", 32'(host.rsp_data), 32'(exp_data));
            check_output("stall_req_ready", 32'(host.req_ready), 32'd0);
        end
        host.rsp_ready = 1'b1;
        @(posedge count_clk);
        #1;
        check_output("exit_rsp_valid", 32'(host.rsp_valid), 32'd0);
        check_output("exit_req_ready", 32'(host.req_ready), 32'd1);
        check_output("exit_busy", 32'(busy), 32'd0);
        check_output("exit_rsp_data_held", 32'(host.rsp_data), 32'(exp_data));
        host.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rc [NUM_RO];
        host.req_valid     = 1'b0;
        host.req_challenge = '0;
        host.rsp_ready     = 1'b0;
        cfg[0] = '0; cfg[1] = '0; cfg[2] = '0;
        #1 check_reset_values();
        repeat (2) @(negedge count_clk);
        reset = 1'b0;

        $display("[TB] directed scans");
        apply_stimulus(8'h2A, 32'd50, 32'd30, 32'd40, 5, 1'b0, -1);
        apply_stimulus(8'h95, 32'd20, 32'd20, 32'd21, 0, 1'b1, -1);
        apply_stimulus(8'h3C, 32'd5, 32'd40, 32'd40, 0, 1'b0, -1);

        $display("[TB] reset mid-scan");
        apply_stimulus(8'h17, 32'd60, 32'd10, 32'd90, 0, 1'b0, 20);
        check_output("post_abort_rsp_data", 32'(host.rsp_data), 32'd0);
        apply_stimulus(8'h0F, 32'd70, 32'd80, 32'd75, 1, 1'b0, -1);

        $display("[TB] randomized scans");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_RO; i++) begin
                rc[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 60));
            end
            apply_stimulus(8'($urandom), rc[0], rc[1], rc[2], int'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ro_scan_scheduler.md
# ro_scan_scheduler

Sequencer that owns the ring-oscillator bank and its shared edge counter. It accepts one challenge at a time over a valid/ready handshake, enables each oscillator in turn for a fixed counting window, and captures every count. When the scan is done it returns the adjacent-pair comparison response, also over valid/ready. It sits between the host-side challenge interface and the RO bank plus counter, and replaces ad-hoc enable/reset sequencing with a deterministic, cycle-exact schedule.

## Interface
- NUM_RO, 9: number of oscillators scanned per challenge (2..16).
- CNT_W, 32: width of the shared edge counter value.
- SETTLE, 16: cycles the oscillator runs with the counter held clear before the window opens (≥1).
- WINDOW, 65536: cycles the counter gate is open (≥1).
- HOLD, 4: quiet cycles after the gate closes before sampling `cnt_value` (≥2, covers counter-domain sync).
- MIN_COUNT, 16: dead-oscillator threshold (used only with the config macro).
- count_clk input 1: block clock; all state changes on its rising edge.
- reset input 1: asynchronous, active-high.
- req_valid input 1: challenge request.
- req_ready output 1: high only in IDLE.
- req_challenge input 8: challenge; bits [5:0] drive the RO path select.
- ro_challenge output 6: latched challenge[5:0], stable for the whole scan.
- ro_en output NUM_RO: one-hot oscillator enable.
- cnt_clear output 1: holds the shared counter at zero.
- cnt_gate output 1: counter increments only while high.
- cnt_value input CNT_W: shared counter value, stable when cnt_gate has been low ≥HOLD cycles.
- rsp_valid output 1: response available.
- rsp_ready input 1: response consumed.
- rsp_data output NUM_RO-1: bit i = count[i] > count[i+1], unsigned; equal counts give 0.
- rsp_err output NUM_RO: bit i = oscillator i is dead.
- busy output 1: state ≠ IDLE.

## Operation
- States: IDLE, SETTLE, GATE, HOLD, CAPTURE, DONE. A 4-bit index `idx` and a cycle counter `tcnt` sized for max(SETTLE, WINDOW, HOLD).
- IDLE: req_ready=1. When req_valid && req_ready: latch ro_challenge, set idx=0, tcnt=0, go to SETTLE.
- SETTLE: ro_en=1<<idx, cnt_clear=1, cnt_gate=0. Stays exactly SETTLE cycles, then goes to GATE.
- GATE: ro_en held, cnt_clear=0, cnt_gate=1. Stays exactly WINDOW cycles, then goes to HOLD.
- HOLD: ro_en held, gate low. Stays exactly HOLD cycles, then goes to CAPTURE.
- CAPTURE: one cycle. Stores count[idx]=cnt_value; ro_en=0.
  - If idx==NUM_RO-1, go to DONE.
  - Otherwise idx+1, tcnt=0, go to SETTLE.
- DONE: rsp_valid=1. rsp_data and rsp_err are registered on DONE entry and held stable while rsp_valid is high. On rsp_ready, go to IDLE.
- req_valid is ignored outside IDLE; no queuing, no challenge change mid-scan.
- ro_en is all-zero in IDLE, CAPTURE and DONE. It is never more than one-hot.

## Timing
- Reset values: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, ro_en=0, cnt_clear=1, cnt_gate=0, ro_challenge=0, all stored counts=0.
- Per-oscillator slot: P = SETTLE + WINDOW + HOLD + 1 cycles.
- rsp_valid rises exactly NUM_RO·P cycles after the accepting edge.
- rsp_ready held high in DONE gives a return to IDLE on the next edge. req_ready is high again on that same edge, so back-to-back scans are separated by one DONE cycle.
- Reset mid-scan aborts immediately: outputs take reset values asynchronously and the partial result is discarded.
- A count at full scale (all ones) is stored unmodified; the scheduler performs no wrap detection.

## Configuration
- RO_SCAN_DEAD_CHECK_EN defined: rsp_err[i]=1 when count[i] < MIN_COUNT. rsp_data is still computed normally.
- RO_SCAN_DEAD_CHECK_EN undefined: rsp_err is tied to 0 and no comparator logic is built. The port list is unchanged.

## Structure
- Package `ro_puf_pkg`: state enum `ro_scan_state_e`, default NUM_RO/CNT_W localparams, and response/error struct typedef.
- One sub-module: `ro_pair_compare`, combinational NUM_RO count array to rsp_data/rsp_err. The scheduler registers its outputs on DONE entry.

## Test plan
Bench parameters: NUM_RO=3, SETTLE=2, WINDOW=8, HOLD=2 (P=13), with a counter model returning the configured counts.
- Counts {50,30,40}, challenge 8'h2A -> rsp_valid at cycle 39 after accept, rsp_data=2'b01, ro_challenge=6'h2A throughout.
- Counts {20,20,21} -> rsp_data=2'b00 (equality gives 0).
- req_valid pulsed during the scan -> ignored, req_ready=0, busy=1 until DONE exits.
- rsp_ready held low 5 cycles in DONE -> rsp_valid/rsp_data stable; accept on cycle 6 -> IDLE next edge.
- Reset asserted at cycle 20 -> ro_en=0, cnt_clear=1, rsp_valid=0 immediately; a new scan then completes normally.
- With RO_SCAN_DEAD_CHECK_EN and MIN_COUNT=16, counts {5,40,40} -> rsp_err=3'b001. Without the macro -> rsp_err=0.
